// File: rtl/cam_bank_scheduler.sv
// rtl/cam_bank_scheduler.sv - frame-buffer bank sequencer with Wishbone control/status registers
module cam_bank_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int DROP_W    = 16
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RSTn_i,
  input  logic [1:0]  WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic        WBs_STB_i,
  input  logic        WBs_WE_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  input  logic        cap_frame_start_i,
  input  logic        cap_bank_done_i,
  output logic        cap_en_o,
  output logic [1:0]  cap_bank_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, CAPTURE = 2'd2, STALL = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic                   enable_q, irq_en_q;
  logic [NUM_BANKS-1:0]   full_q, full_d, rel_mask, set_mask;
  logic [1:0]             cap_bank_q, bank_nxt;
  logic                   overflow_q;
  logic [DROP_W-1:0]      drops_q;
  logic                   wb_wr, ctrl_wr, rel_wr, rel_ovf;
  logic                   done_evt, drop_evt;
  logic [31:0]            rdata;
  logic                   unused_dat;

  assign wb_wr   = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~WBs_ACK_o;
  assign ctrl_wr = wb_wr & (WBs_ADR_i == 2'd0);
  assign rel_wr  = wb_wr & (WBs_ADR_i == 2'd2);
  assign rel_mask = rel_wr ? WBs_DAT_i[NUM_BANKS-1:0] : '0;
  assign rel_ovf  = rel_wr & WBs_DAT_i[8];
  assign unused_dat = ^{WBs_DAT_i[31:9], WBs_DAT_i[7:4]};

  assign done_evt = (state_q == CAPTURE) & cap_bank_done_i;
  assign drop_evt = cap_frame_start_i &
                    (((state_q == WAIT_FRAME) & full_q[cap_bank_q]) | (state_q == STALL));
  assign bank_nxt = cap_bank_q + 2'd1;

  // A completing bank's set is applied after the release so the set wins on the same bank
  always_comb begin
    set_mask = '0;
    set_mask[cap_bank_q] = done_evt;
    full_d = (full_q & ~rel_mask) | set_mask;
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = WAIT_FRAME;
        WAIT_FRAME: if (cap_frame_start_i && !full_q[cap_bank_q]) state_d = CAPTURE;
        CAPTURE:    if (cap_bank_done_i && full_d[bank_nxt]) state_d = STALL;
        STALL:      if (!full_q[cap_bank_q]) state_d = WAIT_FRAME;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cap_en_o = (state_q == CAPTURE);
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      WBs_ACK_o  <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      full_q     <= '0;
      cap_bank_q <= 2'd0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      WBs_ACK_o <= WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
      if (ctrl_wr) begin
        enable_q <= WBs_DAT_i[0];
        irq_en_q <= WBs_DAT_i[1];
      end
      full_q <= full_d;
      if (done_evt) cap_bank_q <= bank_nxt;
      if (drop_evt)     overflow_q <= 1'b1;
      else if (rel_ovf) overflow_q <= 1'b0;
      if (drop_evt && (drops_q != '1)) drops_q <= drops_q + DROP_W'(1);
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (WBs_ADR_i)
      2'd0:    rdata = {30'd0, irq_en_q, enable_q};
      2'd1:    rdata = {22'd0, state_q, 1'b0, overflow_q, cap_bank_q, full_q};
      2'd3:    rdata = 32'(drops_q);
      default: rdata = 32'd0;
    endcase
  end

  assign WBs_DAT_o  = WBs_ACK_o ? rdata : 32'd0;
  assign cap_bank_o = cap_bank_q;
  assign irq_o      = irq_en_q & (|full_q);

endmodule
